// File: rtl/sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2
// Single-clock FIFO for spike/frame word streams between the preprocessing and
// core datapaths. It has generic depth and width and an optional
// first-word-fall-through read port. It reports occupancy and programmable
// almost-full/almost-empty flags. Overflow and underflow flags are sticky, and
// a synchronous flush is provided. In registered-read mode an optional
// auto-close writes an EOF marker into rd_data when a SOF marker is left
// dangling on the read port after the FIFO has drained.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   flush        synchronous clear of pointers/count (one-cycle pulse)
//   wr_en        write request
//   wr_data      write word
//   rd_en        read request (FWFT=1: acknowledge/pop of the head word)
//   rd_data      read word
//   rd_valid     FWFT=0: one-cycle pulse when a read updated rd_data
//                FWFT=1: head word present (!fifo_empty)
//   af_thresh    almost-full threshold  (almost_full  = count >= af_thresh)
//   ae_thresh    almost-empty threshold (almost_empty = count <= ae_thresh)
//   count        occupancy 0..DEPTH
//   fifo_full    count == DEPTH
//   fifo_empty   count == 0
//   almost_full  count >= af_thresh
//   almost_empty count <= ae_thresh
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
//   clr_err      clears overflow/underflow
//   eof_ins      one-cycle pulse when auto-close rewrites rd_data
// -----------------------------------------------------------------------------
module sync_fifo_v2 #(
    parameter int                WIDTH      = 16,
    parameter int                DEPTH      = 1024,
    parameter int                ADDR_WIDTH = 10,
    parameter int                FWFT       = 0,
    parameter int                CLOSE_EN   = 1,
    parameter int                CLOSE_DLY  = 1,
    parameter logic [WIDTH-1:0]  SOF_WORD   = 16'hFAF1,
    parameter logic [WIDTH-1:0]  EOF_WORD   = 16'hF1FA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic                  eof_ins
);

    // Increment constant sized to the pointer/count width.
    localparam logic [ADDR_WIDTH:0] PTR_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [7:0]          CLOSE_DLY_V = 8'(CLOSE_DLY);
    // Auto-close only exists on the registered-read port.
    localparam bit                  CLOSE_ACT   = (FWFT == 0) && (CLOSE_EN != 0);

    // Storage: deliberately not reset so it can map onto RAM.
    logic [WIDTH-1:0]      mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_r;
    logic [ADDR_WIDTH:0]   rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Full when the pointers address the same slot but are a lap apart.
    assign full_s   = (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]) &&
                      (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);

    // A write is never accepted while full, even alongside a read.
    assign wr_acc_s = wr_en && !full_s;
    assign rd_acc_s = rd_en && !empty_s;

    assign fifo_full    = full_s;
    assign fifo_empty   = empty_s;
    assign count        = count_r;
    assign almost_full  = (count_r >= af_thresh);
    assign almost_empty = (count_r <= ae_thresh);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + PTR_ONE;
            2'b01:   count_nxt_s = count_r - PTR_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers; flush clears them like reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // RAM write port; writes are ignored while reset or flush take priority.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst && !flush) begin
            mem[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Sticky error flags; a fresh error in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end else begin
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] rd_data_r;
            logic             rd_valid_r;
            logic             eof_ins_r;
            logic [7:0]       idle_r;
            logic             cond_s;
            logic             fire_s;

            // A SOF marker is still on the read port with nothing behind it.
            assign cond_s = CLOSE_ACT && empty_s && (rd_data_r == SOF_WORD);
            assign fire_s = cond_s && (idle_r == CLOSE_DLY_V);

            // Registered read port, idle counter and EOF insertion.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_r  <= '0;
                    rd_valid_r <= 1'b0;
                    eof_ins_r  <= 1'b0;
                    idle_r     <= 8'd0;
                end else if (flush) begin
                    rd_data_r  <= rd_data_r;
                    rd_valid_r <= 1'b0;
                    eof_ins_r  <= 1'b0;
                    idle_r     <= 8'd0;
                end else begin
                    rd_valid_r <= rd_acc_s;
                    eof_ins_r  <= fire_s;
                    // cond implies empty, so a read and a firing never coincide.
                    if (rd_acc_s) begin
                        rd_data_r <= mem[rd_ptr_r[ADDR_WIDTH-1:0]];
                    end else if (fire_s) begin
                        rd_data_r <= EOF_WORD;
                    end else begin
                        rd_data_r <= rd_data_r;
                    end
                    // Counter never passes CLOSE_DLY: it restarts on firing.
                    if (!cond_s || fire_s) begin
                        idle_r <= 8'd0;
                    end else begin
                        idle_r <= idle_r + 8'd1;
                    end
                end
            end

            assign rd_data  = rd_data_r;
            assign rd_valid = rd_valid_r;
            assign eof_ins  = eof_ins_r;
        end else begin : g_fwft
            // Head word is presented directly; meaningless while empty.
            assign rd_data  = mem[rd_ptr_r[ADDR_WIDTH-1:0]];
            assign rd_valid = !empty_s;
            assign eof_ins  = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_v2
// Directed bench for sync_fifo_v2. u0 is the default 1024x16 registered-read
// FIFO with auto-close. u1 is a small first-word-fall-through instance.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_v2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // u0: registered read, DEPTH 1024
    logic        rst, flush, wr_en, rd_en, clr_err;
    logic [15:0] wr_data, rd_data;
    logic [10:0] af_thresh, ae_thresh, count;
    logic        rd_valid, fifo_full, fifo_empty, almost_full, almost_empty;
    logic        overflow, underflow, eof_ins;

    // u1: first-word-fall-through, DEPTH 4
    logic        flush1, wr_en1, rd_en1, clr_err1;
    logic [15:0] wr_data1, rd_data1;
    logic [2:0]  af_thresh1, ae_thresh1, count1;
    logic        rd_valid1, fifo_full1, fifo_empty1, almost_full1, almost_empty1;
    logic        overflow1, underflow1, eof_ins1;

    int compared   = 0;
    int mismatched = 0;

    sync_fifo_v2 u0 (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
        .eof_ins(eof_ins)
    );

    sync_fifo_v2 #(.WIDTH(16), .DEPTH(4), .ADDR_WIDTH(2), .FWFT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush1), .wr_en(wr_en1), .wr_data(wr_data1),
        .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .af_thresh(af_thresh1), .ae_thresh(ae_thresh1), .count(count1),
        .fifo_full(fifo_full1), .fifo_empty(fifo_empty1),
        .almost_full(almost_full1), .almost_empty(almost_empty1),
        .overflow(overflow1), .underflow(underflow1), .clr_err(clr_err1),
        .eof_ins(eof_ins1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        wr_data = 16'h0000; af_thresh = 11'd1000; ae_thresh = 11'd3;
        flush1 = 1'b0; wr_en1 = 1'b0; rd_en1 = 1'b0; clr_err1 = 1'b0;
        wr_data1 = 16'h0000; af_thresh1 = 3'd3; ae_thresh1 = 3'd1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", count, 32'd0);
        check("rst_empty", fifo_empty, 32'd1);
        check("rst_full", fifo_full, 32'd0);
        check("rst_rd_valid", rd_valid, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_eof_ins", eof_ins, 32'd0);
        check("rst_ae", almost_empty, 32'd1);
        check("rst_af", almost_full, 32'd0);
        check("rst_fwft_valid", rd_valid1, 32'd0);

        // FWFT: head word visible without rd_en, pop clears rd_valid
        wr_en1 = 1'b1; wr_data1 = 16'h1234;
        tick();
        wr_en1 = 1'b0;
        check("fwft_valid", rd_valid1, 32'd1);
        check("fwft_data", rd_data1, 32'h1234);
        wr_en1 = 1'b1; wr_data1 = 16'h5678;
        tick();
        wr_en1 = 1'b0; rd_en1 = 1'b1;
        tick();
        check("fwft_head2", rd_data1, 32'h5678);
        check("fwft_valid2", rd_valid1, 32'd1);
        tick();
        rd_en1 = 1'b0;
        check("fwft_pop_valid", rd_valid1, 32'd0);
        check("fwft_pop_empty", fifo_empty1, 32'd1);
        check("fwft_no_uf", underflow1, 32'd0);

        // Fill all 1024 entries, almost_full crosses between 999 and 1000
        wr_en = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            wr_data = 16'(i);
            tick();
            if (i == 999)  check("af_at_999", almost_full, 32'd0);
            if (i == 1000) check("af_at_1000", almost_full, 32'd1);
        end
        check("fill_full", fifo_full, 32'd1);
        check("fill_count", count, 32'd1024);
        wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        check("ovf_flag", overflow, 32'd1);
        check("ovf_count", count, 32'd1024);

        // Drain in order; almost_empty crosses between 4 and 3
        rd_en = 1'b1;
        for (int i = 1; i <= 1024; i++) begin
            tick();
            check("drain_data", rd_data, 32'(i));
            check("drain_valid", rd_valid, 32'd1);
            if (1024 - i == 4) check("ae_at_4", almost_empty, 32'd0);
            if (1024 - i == 3) check("ae_at_3", almost_empty, 32'd1);
        end
        rd_en = 1'b0;
        tick();
        check("drain_empty", fifo_empty, 32'd1);
        check("drain_valid_low", rd_valid, 32'd0);
        check("drain_hold", rd_data, 32'h0400);
        check("ovf_sticky", overflow, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", overflow, 32'd0);

        // count=5 with simultaneous read+write; run long enough to wrap the pointers
        wr_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = 16'(32'h100 + k);
            tick();
        end
        check("rw_count_start", count, 32'd5);
        rd_en = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            wr_data = 16'(32'h200 + k);
            tick();
            check("rw_data", rd_data, (k < 5) ? 32'h100 + k : 32'h200 + k - 5);
            check("rw_count", count, 32'd5);
        end
        wr_en = 1'b0;
        for (int k = 1095; k < 1100; k++) begin
            tick();
            check("rw_tail", rd_data, 32'h200 + k);
        end
        rd_en = 1'b0;
        tick();
        check("rw_empty", fifo_empty, 32'd1);

        // Auto-close: EOF appears two edges after the SOF is read out
        wr_en = 1'b1; wr_data = 16'hFAF1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("ac_sof", rd_data, 32'hFAF1);
        check("ac_sof_eof", eof_ins, 32'd0);
        tick();
        check("ac_wait_data", rd_data, 32'hFAF1);
        check("ac_wait_eof", eof_ins, 32'd0);
        tick();
        check("ac_fire_data", rd_data, 32'hF1FA);
        check("ac_fire_eof", eof_ins, 32'd1);
        tick();
        check("ac_pulse_end", eof_ins, 32'd0);
        check("ac_hold", rd_data, 32'hF1FA);

        // Auto-close still fires with a write at the firing edge
        wr_en = 1'b1; wr_data = 16'hFAF1;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("acw_wait", rd_data, 32'hFAF1);
        wr_en = 1'b1; wr_data = 16'h5555;
        tick();
        wr_en = 1'b0;
        check("acw_fire_data", rd_data, 32'hF1FA);
        check("acw_fire_eof", eof_ins, 32'd1);
        check("acw_count", count, 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("acw_read", rd_data, 32'h5555);
        check("acw_eof_low", eof_ins, 32'd0);

        // Flush overrides simultaneous write and read
        wr_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_data = 16'(32'h300 + k);
            tick();
        end
        check("fl_count10", count, 32'd10);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hAAAA;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check("fl_count", count, 32'd0);
        check("fl_empty", fifo_empty, 32'd1);
        check("fl_rd_data", rd_data, 32'h5555);
        check("fl_rd_valid", rd_valid, 32'd0);
        rd_en = 1'b1;
        tick();
        check("uf_set", underflow, 32'd1);
        check("uf_no_valid", rd_valid, 32'd0);
        clr_err = 1'b1;
        tick();
        check("uf_err_wins", underflow, 32'd1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        check("uf_clr", underflow, 32'd0);

        // Reset mid-stream discards contents
        wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_data = 16'(32'h400 + k);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("mid_rst_count", count, 32'd0);
        check("mid_rst_empty", fifo_empty, 32'd1);
        check("mid_rst_data", rd_data, 32'd0);
        wr_en = 1'b1; wr_data = 16'h7777;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("mid_rst_new", rd_data, 32'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
